// File: rtl/fsk_tx_param.sv
// Binary FSK transmitter: serialises DATA_W-bit words LSB-first as square-wave tones,
// BIT_CYCLES clocks per bit, with continuous output phase across bit boundaries.
module fsk_tx_param #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 16,
  parameter int HALF0      = 1,
  parameter int HALF1      = 2,
  parameter int IDLE_TONE  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              fsk_out,
  output logic              tx_active,
  output logic              tx_done
);

  localparam int HALF_MAX = (HALF0 > HALF1) ? HALF0 : HALF1;
  localparam int CNT_W    = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IDX_W    = (DATA_W > 1)     ? $clog2(DATA_W)     : 1;
  localparam int HALF_W   = (HALF_MAX > 1)   ? $clog2(HALF_MAX)   : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BIT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_W - 1);
  localparam logic [HALF_W-1:0] H0_LAST  = HALF_W'(HALF0 - 1);
  localparam logic [HALF_W-1:0] H1_LAST  = HALF_W'(HALF1 - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  state_e              state_q,   state_d;
  logic [DATA_W-1:0]   shift_q,   shift_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
  logic [HALF_W-1:0]   half_q,    half_d;
  logic                fsk_q,     fsk_d;
  logic                done_q,    done_d;

  logic                bit_last_s;
  logic                word_last_s;
  logic                accept_s;
  logic [HALF_W-1:0]   h_last_s;

  assign bit_last_s  = (bit_cnt_q == CNT_LAST);
  assign word_last_s = (state_q == ST_SEND) && bit_last_s && (bit_idx_q == IDX_LAST);
  assign tx_ready    = (state_q == ST_IDLE) || word_last_s;
  assign accept_s    = tx_valid && tx_ready;
  assign h_last_s    = shift_q[0] ? H1_LAST : H0_LAST;

  assign fsk_out   = fsk_q;
  assign tx_done   = done_q;
  assign tx_active = (state_q == ST_SEND);

  // Next-state logic: tone generation, bit/word sequencing and word load on accept
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    half_d    = half_q;
    fsk_d     = fsk_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (IDLE_TONE != 0) begin
          if (half_q == H1_LAST) begin
            fsk_d  = ~fsk_q;
            half_d = {HALF_W{1'b0}};
          end else begin
            half_d = half_q + HALF_W'(1);
          end
        end else begin
          fsk_d  = 1'b0;
          half_d = {HALF_W{1'b0}};
        end
      end
      ST_SEND: begin
        if (half_q == h_last_s) begin
          fsk_d  = ~fsk_q;
          half_d = {HALF_W{1'b0}};
        end else begin
          half_d = half_q + HALF_W'(1);
        end
        // Output level carries over bit boundaries; only the half-period counter restarts
        if (bit_last_s) begin
          bit_cnt_d = {CNT_W{1'b0}};
          half_d    = {HALF_W{1'b0}};
          shift_d   = shift_q >> 1;
          if (bit_idx_q == IDX_LAST) begin
            bit_idx_d = {IDX_W{1'b0}};
            state_d   = ST_IDLE;
            done_d    = 1'b1;
            if (IDLE_TONE == 0) begin
              fsk_d = 1'b0;
            end else begin
              fsk_d = fsk_d;
            end
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept_s) begin
      shift_d   = tx_data;
      bit_cnt_d = {CNT_W{1'b0}};
      bit_idx_d = {IDX_W{1'b0}};
      half_d    = {HALF_W{1'b0}};
      fsk_d     = 1'b1;
      state_d   = ST_SEND;
    end else begin
      state_d = state_d;
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shift_q   <= {DATA_W{1'b0}};
      bit_cnt_q <= {CNT_W{1'b0}};
      bit_idx_q <= {IDX_W{1'b0}};
      half_q    <= {HALF_W{1'b0}};
      fsk_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      half_q    <= half_d;
      fsk_q     <= fsk_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_fsk_tx_param.sv
// Directed bench for fsk_tx_param: three instances cover BIT_CYCLES=4, BIT_CYCLES=3
// and the free-running idle tone.
module tb_fsk_tx_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_a, data_b, data_c;
  logic       valid_a, valid_b, valid_c;
  logic       ready_a, ready_b, ready_c;
  logic       fsk_a, fsk_b, fsk_c;
  logic       active_a, active_b, active_c;
  logic       done_a, done_b, done_c;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fsk_tx_param #(.DATA_W(8), .BIT_CYCLES(4), .HALF0(1), .HALF1(2), .IDLE_TONE(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .tx_data(data_a), .tx_valid(valid_a), .tx_ready(ready_a),
    .fsk_out(fsk_a), .tx_active(active_a), .tx_done(done_a));

  fsk_tx_param #(.DATA_W(8), .BIT_CYCLES(3), .HALF0(1), .HALF1(2), .IDLE_TONE(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .tx_data(data_b), .tx_valid(valid_b), .tx_ready(ready_b),
    .fsk_out(fsk_b), .tx_active(active_b), .tx_done(done_b));

  fsk_tx_param #(.DATA_W(8), .BIT_CYCLES(4), .HALF0(1), .HALF1(2), .IDLE_TONE(1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .tx_data(data_c), .tx_valid(valid_c), .tx_ready(ready_c),
    .fsk_out(fsk_c), .tx_active(active_c), .tx_done(done_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-derived per-bit tone for BIT_CYCLES=4: bit 1 -> 1,1,0,0 ; bit 0 -> 1,0,1,0
  function automatic logic exp_a(input logic [7:0] w, input int k);
    int pos;
    pos = (k - 1) % 4;
    if (w[(k - 1) / 4]) return (pos < 2);
    else                return (pos % 2 == 0);
  endfunction

  // Send one word on instance A from idle, with a stray valid pulse mid-word
  task automatic send_a(input logic [7:0] w, input string tag);
    valid_a = 1'b1;
    data_a  = w;
    tick();
    valid_a = 1'b0;
    data_a  = 8'h00;
    for (int k = 1; k <= 32; k++) begin
      check({tag, "_fsk"}, {31'd0, fsk_a}, {31'd0, exp_a(w, k)});
      check({tag, "_active"}, {31'd0, active_a}, 32'd1);
      check({tag, "_done"}, {31'd0, done_a}, 32'd0);
      check({tag, "_ready"}, {31'd0, ready_a}, (k == 32) ? 32'd1 : 32'd0);
      valid_a = (k == 10);
      data_a  = (k == 10) ? 8'h3C : 8'h00;
      tick();
    end
    check({tag, "_done33"}, {31'd0, done_a}, 32'd1);
    check({tag, "_idle33"}, {31'd0, active_a}, 32'd0);
    tick();
    check({tag, "_done34"}, {31'd0, done_a}, 32'd0);
  endtask

  initial begin
    logic [23:0] exp_b;
    logic [7:0]  exp_c;
    int          dones;

    rst_n   = 1'b0;
    valid_a = 1'b1; valid_b = 1'b1; valid_c = 1'b1;
    data_a  = 8'hA5; data_b = 8'hA5; data_c = 8'hA5;

    // Reset held three clocks with valid asserted
    tick(); tick(); tick();
    check("rst_fsk", {31'd0, fsk_a}, 32'd0);
    check("rst_ready", {31'd0, ready_a}, 32'd1);
    check("rst_active", {31'd0, active_a}, 32'd0);
    check("rst_done", {31'd0, done_a}, 32'd0);
    valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
    rst_n   = 1'b1;
    tick();
    check("rst_no_accept_a", {31'd0, active_a}, 32'd0);
    check("rst_no_accept_b", {31'd0, active_b}, 32'd0);
    check("rst_no_accept_c", {31'd0, active_c}, 32'd0);

    // Single word 8'hA5
    send_a(8'hA5, "a5");

    // Back-to-back 8'h00 then 8'hFF with valid held high
    valid_a = 1'b1;
    data_a  = 8'h00;
    tick();
    data_a = 8'hFF;
    for (int k = 1; k <= 32; k++) begin
      check("b2b_w0_fsk", {31'd0, fsk_a}, {31'd0, exp_a(8'h00, k)});
      check("b2b_w0_done", {31'd0, done_a}, 32'd0);
      check("b2b_w0_ready", {31'd0, ready_a}, (k == 32) ? 32'd1 : 32'd0);
      tick();
    end
    for (int k = 1; k <= 32; k++) begin
      check("b2b_w1_fsk", {31'd0, fsk_a}, {31'd0, exp_a(8'hFF, k)});
      check("b2b_w1_active", {31'd0, active_a}, 32'd1);
      check("b2b_w1_done", {31'd0, done_a}, (k == 1) ? 32'd1 : 32'd0);
      valid_a = 1'b0;
      tick();
    end
    check("b2b_done_end", {31'd0, done_a}, 32'd1);
    check("b2b_idle_end", {31'd0, active_a}, 32'd0);
    tick();

    // Bit boundaries with BIT_CYCLES=3: each 1-bit is s,s,~s and the next bit starts at ~s
    exp_b   = 24'b100011_100011_100011_100011;
    valid_b = 1'b1;
    data_b  = 8'hFF;
    tick();
    valid_b = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      check("bc3_fsk", {31'd0, fsk_b}, {31'd0, exp_b[k-1]});
      check("bc3_active", {31'd0, active_b}, 32'd1);
      tick();
    end
    check("bc3_done", {31'd0, done_b}, 32'd1);
    check("bc3_idle", {31'd0, active_b}, 32'd0);

    // Reset during bit 3 aborts the word without tx_done
    valid_a = 1'b1;
    data_a  = 8'h0F;
    tick();
    valid_a = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      check("abort_fsk", {31'd0, fsk_a}, {31'd0, exp_a(8'h0F, k)});
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_active", {31'd0, active_a}, 32'd0);
    check("abort_fsk_low", {31'd0, fsk_a}, 32'd0);
    check("abort_done", {31'd0, done_a}, 32'd0);
    check("abort_ready", {31'd0, ready_a}, 32'd1);
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      dones += int'(done_a);
    end
    check("abort_no_done", dones, 32'd0);
    send_a(8'h5A, "after_abort");

    // Idle tone on instance C, phase fixed by a reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_c = 8'b11001100;
    for (int k = 0; k < 8; k++) begin
      check("idle_tone", {31'd0, fsk_c}, {31'd0, exp_c[k]});
      if (k < 7) tick();
    end
    valid_c = 1'b1;
    data_c  = 8'h00;
    tick();
    valid_c = 1'b0;
    check("tone_accept_fsk", {31'd0, fsk_c}, 32'd1);
    check("tone_accept_active", {31'd0, active_c}, 32'd1);
    check("tone_accept_ready", {31'd0, ready_c}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
